// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined-datapath controller: opcodes, functs,
// ALU codes, forward-select encodings and the decoded control bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Register 0 is hard-wired to zero, so a match on it is never a real dependency.
  function automatic logic regMatch(input logic [4:0] src, input logic [4:0] dst,
                                    input logic en);
    return en && (src != 5'd0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwdSelect(input logic [4:0] src,
                                           input logic [4:0] dstM, input logic enM,
                                           input logic [4:0] dstW, input logic enW);
    if (regMatch(src, dstM, enM)) return FWD_MEM;
    if (regMatch(src, dstW, enW)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decoder: op/funct -> control bundle.
// Unknown opcodes and unknown R-type functs decode to an all-zero NOP bundle.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NOP;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = 1'b1;
        case (i_funct)
          FUNCT_ADD: o_ctrl.alucontrol = ALU_ADD;
          FUNCT_SUB: o_ctrl.alucontrol = ALU_SUB;
          FUNCT_AND: o_ctrl.alucontrol = ALU_AND;
          FUNCT_OR:  o_ctrl.alucontrol = ALU_OR;
          FUNCT_SLT: o_ctrl.alucontrol = ALU_SLT;
          default:   o_ctrl = CTRL_NOP;
        endcase
      end
      OP_LW: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.memtoreg   = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.memwrite   = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch     = 1'b1;
        o_ctrl.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        o_ctrl.regwrite   = 1'b1;
        o_ctrl.alusrc     = 1'b1;
        o_ctrl.alucontrol = ALU_ADD;
      end
      default: o_ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/pipe_controller.sv
// Control and hazard unit for the 5-stage F/D/E/M/W pipeline.
// Define PIPE_CTRL_PERF_EN to add the stall_cnt / taken_cnt performance counters.
module pipe_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             equalD,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  output logic             pcsrcD,
  output logic             regdstE,
  output logic             alusrcE,
  output logic [2:0]       alucontrolE,
  output logic             memwriteM,
  output logic             memtoregW,
  output logic             regwriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] taken_cnt
`endif
);

  ctrl_t      w_ctrlD;
  logic       w_lwStall;
  logic       w_brStall;
  logic       w_stall;

  logic       r_regwriteE;
  logic       r_memtoregE;
  logic       r_memwriteE;
  logic       r_alusrcE;
  logic       r_regdstE;
  logic [2:0] r_alucontrolE;
  logic       r_regwriteM;
  logic       r_memtoregM;
  logic       r_memwriteM;
  logic       r_regwriteW;
  logic       r_memtoregW;

  ctrl_decoder u_decoder (
    .i_op    (op),
    .i_funct (funct),
    .o_ctrl  (w_ctrlD)
  );

  // Only the bits still needed downstream are carried past each stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regwriteE   <= 1'b0;
      r_memtoregE   <= 1'b0;
      r_memwriteE   <= 1'b0;
      r_alusrcE     <= 1'b0;
      r_regdstE     <= 1'b0;
      r_alucontrolE <= 3'b000;
      r_regwriteM   <= 1'b0;
      r_memtoregM   <= 1'b0;
      r_memwriteM   <= 1'b0;
      r_regwriteW   <= 1'b0;
      r_memtoregW   <= 1'b0;
    end else begin
      r_regwriteE   <= w_stall ? 1'b0   : w_ctrlD.regwrite;
      r_memtoregE   <= w_stall ? 1'b0   : w_ctrlD.memtoreg;
      r_memwriteE   <= w_stall ? 1'b0   : w_ctrlD.memwrite;
      r_alusrcE     <= w_stall ? 1'b0   : w_ctrlD.alusrc;
      r_regdstE     <= w_stall ? 1'b0   : w_ctrlD.regdst;
      r_alucontrolE <= w_stall ? 3'b000 : w_ctrlD.alucontrol;
      r_regwriteM   <= r_regwriteE;
      r_memtoregM   <= r_memtoregE;
      r_memwriteM   <= r_memwriteE;
      r_regwriteW   <= r_regwriteM;
      r_memtoregW   <= r_memtoregM;
    end
  end

  // lwstall deliberately compares register 0 too; the branch stall waits for
  // any producer still in E, or a load still in M, feeding the comparator.
  assign w_lwStall = r_memtoregE && ((rsD == rtE) || (rtD == rtE));
  assign w_brStall = w_ctrlD.branch &&
                     ((r_regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                      (r_memtoregM && ((writeregM == rsD) || (writeregM == rtD))));
  assign w_stall   = w_lwStall || w_brStall;

  assign stallF      = w_stall;
  assign stallD      = w_stall;
  assign flushE      = w_stall;
  assign pcsrcD      = w_ctrlD.branch && equalD && !w_stall;

  assign forwardAD   = regMatch(rsD, writeregM, r_regwriteM);
  assign forwardBD   = regMatch(rtD, writeregM, r_regwriteM);
  assign forwardAE   = fwdSelect(rsE, writeregM, r_regwriteM, writeregW, r_regwriteW);
  assign forwardBE   = fwdSelect(rtE, writeregM, r_regwriteM, writeregW, r_regwriteW);

  assign regdstE     = r_regdstE;
  assign alusrcE     = r_alusrcE;
  assign alucontrolE = r_alucontrolE;
  assign memwriteM   = r_memwriteM;
  assign memtoregW   = r_memtoregW;
  assign regwriteW   = r_regwriteW;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (w_stall) stall_cnt <= stall_cnt + CNT_W'(1);
      if (pcsrcD)  taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: an instruction-level pipeline model
// (program queue, per-stage instruction records) plus directed and random programs.
module tb_pipe_controller;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        equalD;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        pcsrcD, regdstE, alusrcE, memwriteM, memtoregW, regwriteW;
  logic [2:0]  alucontrolE;
  logic        stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE;
`ifdef PIPE_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt, taken_cnt;
`endif

  pipe_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equalD(equalD),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .pcsrcD(pcsrcD), .regdstE(regdstE), .alusrcE(alusrcE), .alucontrolE(alucontrolE),
    .memwriteM(memwriteM), .memtoregW(memtoregW), .regwriteW(regwriteW),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       eq;
  } instr_t;

  typedef struct packed {
    bit       rw;
    bit       m2r;
    bit       mw;
    bit       br;
    bit       asrc;
    bit       rdst;
    bit [2:0] alu;
  } ctl_t;

  int tests = 0;
  int fails = 0;

  // Model state: instruction in each stage, whether the controller holds live
  // control bits for it, and the program still to be fetched.
  instr_t dI, eI, mI, wI;
  bit     eV, mV, wV;
  instr_t prog[$];
  bit     expStallNow, expPcsrcNow;
  int     cntStall, cntTaken;

  logic [5:0] functTab [5];
  logic [2:0] aluTab   [5];

  function automatic instr_t mk(logic [5:0] o, logic [5:0] f, logic [4:0] s,
                                logic [4:0] t, logic [4:0] d, logic e);
    instr_t i;
    i.op = o; i.funct = f; i.rs = s; i.rt = t; i.rd = d; i.eq = e;
    return i;
  endfunction

  // Control bits straight from the instruction table.
  function automatic ctl_t decode(instr_t i);
    ctl_t c = '0;
    if (i.op == 6'b000000) begin
      for (int k = 0; k < 5; k++)
        if (i.funct == functTab[k]) begin
          c.rw = 1; c.rdst = 1; c.alu = aluTab[k];
        end
    end else if (i.op == 6'b100011) begin
      c.rw = 1; c.asrc = 1; c.m2r = 1; c.alu = 3'b010;
    end else if (i.op == 6'b101011) begin
      c.asrc = 1; c.mw = 1; c.alu = 3'b010;
    end else if (i.op == 6'b000100) begin
      c.br = 1; c.alu = 3'b110;
    end else if (i.op == 6'b001000) begin
      c.rw = 1; c.asrc = 1; c.alu = 3'b010;
    end
    return c;
  endfunction

  function automatic logic [4:0] destOf(instr_t i);
    return decode(i).rdst ? i.rd : i.rt;
  endfunction

  function automatic logic [1:0] fwdModel(logic [4:0] src, logic [4:0] dM, bit wM,
                                          logic [4:0] dW, bit wW);
    if (src != 0 && src == dM && wM) return 2'b10;
    if (src != 0 && src == dW && wW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Drive the current pipeline contents, then compare every output with the model.
  task automatic applyStimulus();
    ctl_t cD, cE, cM, cW;
    logic [4:0] wrE, wrM, wrW;
    bit lw, brs, stl, pc;
    op = dI.op; funct = dI.funct; rsD = dI.rs; rtD = dI.rt; equalD = dI.eq;
    rsE = eI.rs; rtE = eI.rt;
    wrE = destOf(eI); wrM = destOf(mI); wrW = destOf(wI);
    writeregE = wrE; writeregM = wrM; writeregW = wrW;
    #2;
    cD = decode(dI);
    cE = eV ? decode(eI) : '0;
    cM = mV ? decode(mI) : '0;
    cW = wV ? decode(wI) : '0;
    lw  = cE.m2r && (dI.rs == eI.rt || dI.rt == eI.rt);
    brs = cD.br && ((cE.rw && (wrE == dI.rs || wrE == dI.rt)) ||
                    (cM.m2r && (wrM == dI.rs || wrM == dI.rt)));
    stl = lw || brs;
    pc  = cD.br && dI.eq && !stl;
    checkOutput("pcsrcD",      32'(pcsrcD),      32'(pc));
    checkOutput("regdstE",     32'(regdstE),     32'(cE.rdst));
    checkOutput("alusrcE",     32'(alusrcE),     32'(cE.asrc));
    checkOutput("alucontrolE", 32'(alucontrolE), 32'(cE.alu));
    checkOutput("memwriteM",   32'(memwriteM),   32'(cM.mw));
    checkOutput("memtoregW",   32'(memtoregW),   32'(cW.m2r));
    checkOutput("regwriteW",   32'(regwriteW),   32'(cW.rw));
    checkOutput("stallF",      32'(stallF),      32'(stl));
    checkOutput("stallD",      32'(stallD),      32'(stl));
    checkOutput("flushE",      32'(flushE),      32'(stl));
    checkOutput("forwardAD",   32'(forwardAD),   32'(dI.rs != 0 && dI.rs == wrM && cM.rw));
    checkOutput("forwardBD",   32'(forwardBD),   32'(dI.rt != 0 && dI.rt == wrM && cM.rw));
    checkOutput("forwardAE",   32'(forwardAE),   32'(fwdModel(eI.rs, wrM, cM.rw, wrW, cW.rw)));
    checkOutput("forwardBE",   32'(forwardBE),   32'(fwdModel(eI.rt, wrM, cM.rw, wrW, cW.rw)));
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("stall_cnt",   32'(stall_cnt),   32'(cntStall));
    checkOutput("taken_cnt",   32'(taken_cnt),   32'(cntTaken));
`endif
    expStallNow = stl;
    expPcsrcNow = pc;
  endtask

  // One clock: shift the instruction records the way the datapath would.
  task automatic advance();
    @(posedge clk);
    if (reset === 1'b0) begin
      eV = 0; mV = 0; wV = 0; cntStall = 0; cntTaken = 0;
    end else begin
      if (expStallNow) cntStall = (cntStall + 1) % (1 << CW);
      if (expPcsrcNow) cntTaken = (cntTaken + 1) % (1 << CW);
      wI = mI; wV = mV;
      mI = eI; mV = eV;
      if (expStallNow) begin
        eI = '0; eV = 0;
      end else begin
        eI = dI; eV = 1;
        if (expPcsrcNow)          dI = '0;
        else if (prog.size() > 0) dI = prog.pop_front();
        else                      dI = '0;
      end
    end
    @(negedge clk);
  endtask

  task automatic runNops(int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      advance();
    end
  endtask

  function automatic instr_t randInstr();
    int sel = $urandom_range(0, 9);
    instr_t i;
    i.rs = 5'($urandom_range(0, 3));
    i.rt = 5'($urandom_range(0, 3));
    i.rd = 5'($urandom_range(0, 3));
    i.eq = 1'($urandom_range(0, 1));
    i.funct = 6'($urandom);
    if (sel <= 2) begin
      i.op = 6'b000000;
      if ($urandom_range(0, 5) != 0) i.funct = functTab[$urandom_range(0, 4)];
    end
    else if (sel == 3) i.op = 6'b100011;
    else if (sel == 4) i.op = 6'b101011;
    else if (sel <= 6) i.op = 6'b000100;
    else if (sel == 7) i.op = 6'b001000;
    else if (sel == 8) i.op = 6'($urandom);
    else begin i.op = 6'b000000; i.funct = 6'b000000; end
    return i;
  endfunction

  initial begin
    functTab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    aluTab   = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};
    dI = '0; eI = '0; mI = '0; wI = '0;
    eV = 0; mV = 0; wV = 0;
    cntStall = 0; cntTaken = 0;
    expStallNow = 0; expPcsrcNow = 0;

    // Reset held with garbage on every input: registered outputs stay 0.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dI = instr_t'($urandom); eI = instr_t'($urandom);
      mI = instr_t'($urandom); wI = instr_t'($urandom);
      applyStimulus();
      checkOutput("rst_regwriteW", 32'(regwriteW), 32'd0);
      checkOutput("rst_memtoregW", 32'(memtoregW), 32'd0);
      checkOutput("rst_alucontrolE", 32'(alucontrolE), 32'd0);
      checkOutput("rst_forwardAE", 32'(forwardAE), 32'd0);
      checkOutput("rst_stallD", 32'(stallD), 32'd0);
      advance();
    end
    dI = '0; eI = '0; mI = '0; wI = '0;
    reset = 1'b1;
    runNops(4);
    checkOutput("nop_regwriteW", 32'(regwriteW), 32'd0);

    // add $3,$1,$2 ; sub $4,$3,$1
    prog.push_back(mk(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 1'b0));
    prog.push_back(mk(6'b000000, 6'b100010, 5'd3, 5'd1, 5'd4, 1'b0));
    advance();
    applyStimulus(); advance();
    applyStimulus(); advance();
    applyStimulus();
    checkOutput("t2_forwardAE", 32'(forwardAE), 32'd2);
    checkOutput("t2_alucontrolE", 32'(alucontrolE), 32'd6);
    advance();
    applyStimulus();
    checkOutput("t2_regwriteW", 32'(regwriteW), 32'd1);
    advance();
    runNops(4);

    // lw $5,0($0) ; add $6,$5,$5
    prog.push_back(mk(6'b100011, 6'b000000, 5'd0, 5'd5, 5'd0, 1'b0));
    prog.push_back(mk(6'b000000, 6'b100000, 5'd5, 5'd5, 5'd6, 1'b0));
    advance();
    applyStimulus(); advance();
    applyStimulus();
    checkOutput("t3_stallF", 32'(stallF), 32'd1);
    checkOutput("t3_flushE", 32'(flushE), 32'd1);
    advance();
    applyStimulus();
    checkOutput("t3_stall_after", 32'(stallD), 32'd0);
    advance();
    applyStimulus();
    checkOutput("t3_forwardAE", 32'(forwardAE), 32'd1);
    checkOutput("t3_forwardBE", 32'(forwardBE), 32'd1);
    advance();
    runNops(4);

    // addi $7,$0,1 ; beq $7,$0 with equalD=0
    prog.push_back(mk(6'b001000, 6'b000001, 5'd0, 5'd7, 5'd0, 1'b0));
    prog.push_back(mk(6'b000100, 6'b000011, 5'd7, 5'd0, 5'd0, 1'b0));
    advance();
    applyStimulus(); advance();
    applyStimulus();
    checkOutput("t4_brstall", 32'(stallD), 32'd1);
    checkOutput("t4_pcsrc_stalled", 32'(pcsrcD), 32'd0);
    advance();
    applyStimulus();
    checkOutput("t4_forwardAD", 32'(forwardAD), 32'd1);
    checkOutput("t4_stall_after", 32'(stallD), 32'd0);
    checkOutput("t4_pcsrcD", 32'(pcsrcD), 32'd0);
    advance();
    runNops(4);

    // beq $0,$0 with equalD=1 and no hazard: taken for exactly one cycle
    prog.push_back(mk(6'b000100, 6'b000000, 5'd0, 5'd0, 5'd0, 1'b1));
    advance();
    applyStimulus();
    checkOutput("t5_pcsrcD", 32'(pcsrcD), 32'd1);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("t5_stall_cnt", 32'(stall_cnt), 32'd2);
    checkOutput("t5_taken_before", 32'(taken_cnt), 32'd0);
`endif
    advance();
    applyStimulus();
    checkOutput("t5_pcsrc_once", 32'(pcsrcD), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    checkOutput("t5_taken_after", 32'(taken_cnt), 32'd1);
`endif
    advance();
    runNops(4);

    // lw reaches W, then reset drops asynchronously mid-cycle
    prog.push_back(mk(6'b100011, 6'b000000, 5'd0, 5'd5, 5'd0, 1'b0));
    advance();
    runNops(3);
    applyStimulus();
    checkOutput("t6_memtoregW_pre", 32'(memtoregW), 32'd1);
    checkOutput("t6_regwriteW_pre", 32'(regwriteW), 32'd1);
    reset = 1'b0;
    #1;
    eV = 0; mV = 0; wV = 0; cntStall = 0; cntTaken = 0;
    checkOutput("t6_memtoregW_async", 32'(memtoregW), 32'd0);
    checkOutput("t6_regwriteW_async", 32'(regwriteW), 32'd0);
    advance();
    reset = 1'b1;
    dI = '0;
    runNops(3);
    applyStimulus();
    checkOutput("t6_no_write", 32'(regwriteW), 32'd0);
    advance();

    // Random programs over registers 0..3 to provoke every hazard path
    for (int i = 0; i < 600; i++) begin
      while (prog.size() < 2) prog.push_back(randInstr());
      applyStimulus();
      if (i == 300) begin
        reset = 1'b0;
        #1;
        advance();
        reset = 1'b1;
        dI = '0;
        prog.delete();
      end else begin
        advance();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
